// File: rtl/booth_control.sv
// rtl/booth_control.sv - sequencing FSM for a radix-2 Booth multiplier
module booth_control #(
    parameter int N     = 8,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             start,
    input  logic             q0,
    input  logic             qm1,
    output logic             ld_m,
    output logic             ld_q,
    output logic             clr_a,
    output logic             clr_qm1,
    output logic             ld_a,
    output logic             add_sub,
    output logic             shift,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_EVAL  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // State and remaining-iteration registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic and strobe decode; only EVAL looks at the {q0,qm1} pair.
    always_comb begin
        state_nxt = S_IDLE;
        cnt_nxt   = cnt;
        ld_m      = 1'b0;
        ld_q      = 1'b0;
        clr_a     = 1'b0;
        clr_qm1   = 1'b0;
        ld_a      = 1'b0;
        add_sub   = 1'b0;
        shift     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt = start ? S_INIT : S_IDLE;
            end
            S_INIT: begin
                ld_m      = 1'b1;
                ld_q      = 1'b1;
                clr_a     = 1'b1;
                clr_qm1   = 1'b1;
                busy      = 1'b1;
                cnt_nxt   = CNT_W'(N);
                state_nxt = S_EVAL;
            end
            S_EVAL: begin
                busy = 1'b1;
                case ({q0, qm1})
                    2'b10: begin
                        ld_a    = 1'b1;
                        add_sub = 1'b1;
                    end
                    2'b01: begin
                        ld_a    = 1'b1;
                        add_sub = 1'b0;
                    end
                    default: begin
                        ld_a    = 1'b0;
                        add_sub = 1'b0;
                    end
                endcase
                state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                shift     = 1'b1;
                busy      = 1'b1;
                cnt_nxt   = cnt - CNT_W'(1);
                state_nxt = (cnt == CNT_W'(1)) ? S_DONE : S_EVAL;
            end
            S_DONE: begin
                done      = 1'b1;
                busy      = 1'b1;
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign iter_cnt = cnt;

endmodule

// File: tb/tb_booth_control.sv
// tb/tb_booth_control.sv - scoreboard bench for booth_control with a behavioural A/Q/M datapath
module tb_booth_control;

    localparam int N     = 8;
    localparam int CNT_W = $clog2(N + 1);

    logic             clk;
    logic             clear_n;
    logic             start;
    logic             q0;
    logic             qm1;
    logic             ld_m;
    logic             ld_q;
    logic             clr_a;
    logic             clr_qm1;
    logic             ld_a;
    logic             add_sub;
    logic             shift;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] iter_cnt;

    booth_control #(.N(N), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .clear_n  (clear_n),
        .start    (start),
        .q0       (q0),
        .qm1      (qm1),
        .ld_m     (ld_m),
        .ld_q     (ld_q),
        .clr_a    (clr_a),
        .clr_qm1  (clr_qm1),
        .ld_a     (ld_a),
        .add_sub  (add_sub),
        .shift    (shift),
        .busy     (busy),
        .done     (done),
        .iter_cnt (iter_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath: A is one bit wider than the operands so -2^(N-1) as multiplicand works.
    logic           use_dp;
    logic           drv_q0;
    logic           drv_qm1;
    logic [N-1:0]   mcand;
    logic [N-1:0]   mplier;
    logic [N:0]     dp_a;
    logic [N-1:0]   dp_q;
    logic [N-1:0]   dp_m;
    logic           dp_qm1;

    always @(negedge clk) begin
        if (ld_m)    dp_m   <= mcand;
        if (ld_q)    dp_q   <= mplier;
        if (clr_a)   dp_a   <= '0;
        if (clr_qm1) dp_qm1 <= 1'b0;
        if (ld_a)    dp_a   <= add_sub ? dp_a - {dp_m[N-1], dp_m} : dp_a + {dp_m[N-1], dp_m};
        if (shift) begin
            dp_a   <= {dp_a[N], dp_a[N:1]};
            dp_q   <= {dp_a[0], dp_q[N-1:1]};
            dp_qm1 <= dp_q[0];
        end
    end

    assign q0  = use_dp ? dp_q[0] : drv_q0;
    assign qm1 = use_dp ? dp_qm1  : drv_qm1;

    wire [8:0] outs = {ld_m, ld_q, clr_a, clr_qm1, ld_a, add_sub, shift, busy, done};

    localparam logic [8:0] O_IDLE  = 9'b000000000;
    localparam logic [8:0] O_INIT  = 9'b111100010;
    localparam logic [8:0] O_EVAL0 = 9'b000000010;
    localparam logic [8:0] O_SHIFT = 9'b000000110;
    localparam logic [8:0] O_DONE  = 9'b000000011;

    int              checks;
    int              errors;
    int              cyc;
    int              done_q[$];
    logic [2*N-1:0]  prod_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        clear_n = 1'b0;
        start   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            #1;
            checks++;
            if (outs !== O_IDLE || iter_cnt !== '0) begin
                errors++;
                $display("FAIL reset_outputs got outs=%b cnt=%0d want outs=%b cnt=0", outs, iter_cnt, O_IDLE);
            end
        end
        clear_n = 1'b1;
        tick();
        #1;
        checks++;
        if (outs !== O_INIT) begin
            errors++;
            $display("FAIL reset_release_init got %b want %b", outs, O_INIT);
        end
        start = 1'b0;
        for (int i = 0; i < 40 && busy; i++) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_drain_timeout got busy=%b want 0", busy);
        end
    endtask

    task automatic test_no_add();
        logic [8:0] exp_o;
        int         e;
        tick();
        cyc = 0;
        drv_q0  = 1'b0;
        drv_qm1 = 1'b0;
        start   = 1'b1;
        done_q.push_back(18);
        for (int c = 0; c <= 19; c++) begin
            if (c > 0) begin
                tick();
                start = 1'b0;
            end
            #1;
            if (c == 1)                          exp_o = O_INIT;
            else if (c >= 2 && c <= 17 && c % 2 == 0) exp_o = O_EVAL0;
            else if (c >= 3 && c <= 17)          exp_o = O_SHIFT;
            else if (c == 18)                    exp_o = O_DONE;
            else                                 exp_o = O_IDLE;
            checks++;
            if (outs !== exp_o) begin
                errors++;
                $display("FAIL no_add_outs cycle=%0d got %b want %b", cyc, outs, exp_o);
            end
            if (done === 1'b1) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL no_add_done_extra cycle=%0d got done want none", cyc);
                end else begin
                    e = done_q.pop_front();
                    if (cyc !== e) begin
                        errors++;
                        $display("FAIL no_add_done_cycle got %0d want %0d", cyc, e);
                    end
                end
            end
        end
        checks++;
        if (done_q.size() != 0) begin
            errors++;
            $display("FAIL no_add_done_missing got %0d pending want 0", done_q.size());
            done_q.delete();
        end
    endtask

    task automatic test_add_sub();
        int exp_cnt;
        tick();
        cyc = 0;
        start = 1'b1;
        for (int c = 0; c <= 19; c++) begin
            if (c > 0) begin
                tick();
                start = 1'b0;
            end
            {drv_q0, drv_qm1} = (c == 2) ? 2'b10 : (c == 4) ? 2'b01 : 2'b00;
            #1;
            if (c == 2) begin
                checks++;
                if (ld_a !== 1'b1 || add_sub !== 1'b1) begin
                    errors++;
                    $display("FAIL sub_eval got ld_a=%b add_sub=%b want 1 1", ld_a, add_sub);
                end
            end
            if (c == 4) begin
                checks++;
                if (ld_a !== 1'b1 || add_sub !== 1'b0) begin
                    errors++;
                    $display("FAIL add_eval got ld_a=%b add_sub=%b want 1 0", ld_a, add_sub);
                end
            end
            if (c >= 2 && c <= 6) begin
                exp_cnt = 8 - (c - 2) / 2;
                checks++;
                if (iter_cnt !== CNT_W'(exp_cnt)) begin
                    errors++;
                    $display("FAIL iter_cnt cycle=%0d got %0d want %0d", cyc, iter_cnt, exp_cnt);
                end
            end
            if (ld_a === 1'b1 && shift === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL ld_a_with_shift cycle=%0d got both want exclusive", cyc);
            end
        end
        {drv_q0, drv_qm1} = 2'b00;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL add_sub_end_busy got %b want 0", busy);
        end
    endtask

    task automatic test_start_ignored();
        int ndone;
        int e;
        tick();
        cyc = 0;
        ndone = 0;
        start = 1'b1;
        done_q.push_back(18);
        for (int c = 0; c <= 40; c++) begin
            if (c > 0) begin
                tick();
                start = (c == 5 || c == 18);
            end
            #1;
            if (done === 1'b1) begin
                ndone++;
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL ignored_done_extra cycle=%0d got done want none", cyc);
                end else begin
                    e = done_q.pop_front();
                    if (cyc !== e) begin
                        errors++;
                        $display("FAIL ignored_done_cycle got %0d want %0d", cyc, e);
                    end
                end
            end
        end
        start = 1'b0;
        checks++;
        if (ndone !== 1) begin
            errors++;
            $display("FAIL ignored_done_count got %0d want 1", ndone);
        end
        done_q.delete();
    endtask

    task automatic test_start_held();
        int e;
        tick();
        cyc = 0;
        start = 1'b1;
        done_q.push_back(18);
        done_q.push_back(37);
        for (int c = 0; c <= 40; c++) begin
            if (c > 0) begin
                tick();
                if (c >= 37) start = 1'b0;
            end
            #1;
            if (done === 1'b1) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL held_done_extra cycle=%0d got done want none", cyc);
                end else begin
                    e = done_q.pop_front();
                    if (cyc !== e) begin
                        errors++;
                        $display("FAIL held_done_cycle got %0d want %0d", cyc, e);
                    end
                end
            end
        end
        checks++;
        if (done_q.size() != 0) begin
            errors++;
            $display("FAIL held_done_missing got %0d pending want 0", done_q.size());
            done_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        int e;
        tick();
        cyc = 0;
        start = 1'b1;
        for (int c = 0; c <= 46; c++) begin
            if (c > 0) begin
                tick();
                start   = (c == 26);
                clear_n = (c != 7);
            end
            if (c == 26) done_q.push_back(44);
            #1;
            if (c == 8) begin
                checks++;
                if (outs !== O_IDLE || iter_cnt !== '0) begin
                    errors++;
                    $display("FAIL mid_reset_idle got outs=%b cnt=%0d want outs=%b cnt=0", outs, iter_cnt, O_IDLE);
                end
            end
            if (done === 1'b1) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL mid_reset_done_extra cycle=%0d got done want none", cyc);
                end else begin
                    e = done_q.pop_front();
                    if (cyc !== e) begin
                        errors++;
                        $display("FAIL mid_reset_done_cycle got %0d want %0d", cyc, e);
                    end
                end
            end
        end
        start   = 1'b0;
        clear_n = 1'b1;
        checks++;
        if (done_q.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_done_missing got %0d pending want 0", done_q.size());
            done_q.delete();
        end
    endtask

    task automatic test_products();
        logic [N-1:0]   av [3];
        logic [N-1:0]   bv [3];
        logic [2*N-1:0] want [3];
        logic [2*N-1:0] exp_p;
        bit             seen;
        av[0] = 8'd3;    bv[0] = 8'hFB; want[0] = 16'hFFF1;
        av[1] = 8'h80;   bv[1] = 8'h80; want[1] = 16'h4000;
        av[2] = 8'd0;    bv[2] = 8'd77; want[2] = 16'h0000;
        use_dp = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            cyc    = 0;
            mcand  = av[k];
            mplier = bv[k];
            prod_q.push_back(want[k]);
            start  = 1'b1;
            seen   = 1'b0;
            for (int c = 1; c <= 30 && !seen; c++) begin
                tick();
                start = 1'b0;
                #1;
                if (done === 1'b1) begin
                    seen  = 1'b1;
                    exp_p = prod_q.pop_front();
                    checks++;
                    if ({dp_a[N-1:0], dp_q} !== exp_p) begin
                        errors++;
                        $display("FAIL product_%0d got %h want %h", k, {dp_a[N-1:0], dp_q}, exp_p);
                    end
                    checks++;
                    if (cyc !== 2 * N + 2) begin
                        errors++;
                        $display("FAIL product_latency_%0d got %0d want %0d", k, cyc, 2 * N + 2);
                    end
                end
            end
            if (!seen) begin
                checks++;
                errors++;
                $display("FAIL product_timeout_%0d got no done want done", k);
                prod_q.delete();
            end
            start = 1'b0;
        end
        use_dp = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        use_dp  = 1'b0;
        drv_q0  = 1'b0;
        drv_qm1 = 1'b0;
        mcand   = '0;
        mplier  = '0;
        clear_n = 1'b0;
        start   = 1'b0;
        test_reset();
        test_no_add();
        test_add_sub();
        test_start_ignored();
        test_start_held();
        test_reset_mid();
        test_products();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/booth_control.md
Name: booth_control

Overview:
- Sequencing FSM for the radix-2 Booth multiplier.
- Sits directly upstream of the accumulator (A) and multiplier (Q) arithmetic-right-shift registers and the M register/adder.
- Drives their clear/load/shift strobes, examines the {Q0, Q-1} bit pair each iteration, and selects add or subtract.
- Runs N iterations per operation and signals completion with a start/done handshake.

Parameters:
- N, 8, operand width; number of Booth iterations (N >= 1).
- CNT_W, $clog2(N+1), iteration counter width.

Ports:
- clk  input  1  system clock; FSM updates on posedge.
- clear_n  input  1  synchronous, active-low reset.
- start  input  1  request a multiply; accepted only in IDLE.
- q0  input  1  LSB of the Q shift register.
- qm1  input  1  Q-1 flip-flop (bit shifted out of Q).
- ld_m  output  1  load multiplicand register.
- ld_q  output  1  load multiplier into Q.
- clr_a  output  1  clear A register.
- clr_qm1  output  1  clear Q-1 flip-flop.
- ld_a  output  1  load adder result into A.
- add_sub  output  1  adder mode: 1 = A-M, 0 = A+M.
- shift  output  1  arithmetic right shift of A, Q and Q-1 as one unit.
- busy  output  1  operation in progress (INIT through DONE).
- done  output  1  one-cycle pulse; product valid in {A,Q}.
- iter_cnt  output  CNT_W  remaining iterations.

Behaviour:
- Reset:
  - clear_n low at a posedge forces state to IDLE and iter_cnt to 0.
  - All strobes, busy and done are 0 in IDLE.
  - Reset has priority over every other input, including mid-operation. The operation is abandoned; datapath contents are don't-care.
- Output timing:
  - Strobes are Moore-decoded from the state register. The exception is ld_a/add_sub in EVAL, which also decode q0/qm1.
  - The shift registers act on the negedge, so strobes are stable half a cycle before use.
  - q0/qm1 only change at the negedge of INIT or SHIFT cycles, so they are stable for the whole EVAL cycle.
- States:
  - IDLE:
    - All outputs 0.
    - start=1 at posedge -> INIT; otherwise stay.
  - INIT (1 cycle):
    - ld_m=ld_q=clr_a=clr_qm1=1, busy=1.
    - iter_cnt <= N.
    - -> EVAL.
  - EVAL (1 cycle):
    - busy=1.
    - {q0,qm1}=10: ld_a=1, add_sub=1 (subtract).
    - {q0,qm1}=01: ld_a=1, add_sub=0 (add).
    - 00 or 11: ld_a=0, add_sub=0.
    - -> SHIFT.
  - SHIFT (1 cycle):
    - shift=1, busy=1.
    - iter_cnt <= iter_cnt-1.
    - If iter_cnt==1 -> DONE; else -> EVAL.
  - DONE (1 cycle):
    - done=1, busy=1, iter_cnt=0.
    - -> IDLE unconditionally.
- Latency:
  - Cycle 0 is the posedge that samples start in IDLE.
  - INIT is cycle 1; EVAL/SHIFT pairs occupy cycles 2..2N+1; done is high in cycle 2N+2.
  - Minimum start-to-start period is 2N+3 cycles.
- start handling:
  - start is ignored in INIT, EVAL, SHIFT and DONE; it is neither queued nor does it restart the operation.
  - start held high continuously re-triggers from IDLE.
- N=1: INIT, EVAL, SHIFT, DONE; SHIFT goes directly to DONE.
- Never assert ld_a and shift in the same cycle. Never assert any load/clear strobe outside INIT and EVAL.
- Unused/illegal state encodings -> IDLE on the next posedge.

Test Plan:
- Reset check: N=8, clear_n=0 for 2 cycles with start=1 -> all outputs 0, iter_cnt=0. Release reset: start sampled -> INIT next cycle, with ld_m, ld_q, clr_a and clr_qm1 all 1.
- {q0,qm1} held 00, start pulse at cycle 0:
  - no ld_a ever;
  - shift high in cycles 3,5,...,17 (8 pulses);
  - done=1 only in cycle 18;
  - IDLE in cycle 19.
- Bench drives {q0,qm1}=10 in EVAL 1 and 01 in EVAL 2 -> ld_a=1 with add_sub=1 in cycle 2; ld_a=1 with add_sub=0 in cycle 4; iter_cnt reads 8,8,7,7,6.
- start pulsed in cycles 5 and 18 (busy) -> ignored; exactly one done pulse. start held high -> done pulses in cycles 18 and 37.
- clear_n=0 at the posedge ending cycle 7 (during SHIFT) -> IDLE from cycle 8, outputs 0, no done. Subsequent start completes normally in 2N+2 cycles.
- Integrated with the A/Q/Q-1 shift registers and adder, N=8: 3 x -5 -> {A,Q}=16'hFFF1 at done; -128 x -128 -> 16'h4000; 0 x 77 -> 16'h0000.
